// File: rtl/fp_int_acc.sv
// Exponent-aligning accumulate step: aligns a signed accumulator and an unsigned magnitude to the
// smaller exponent, then adds or subtracts. Define FP_INT_ACC_SAT_EN to saturate instead of wrapping.
module fp_int_acc #(
  parameter int ACC_W = 32,
  parameter int IN_W  = 14,
  parameter int EXP_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sign_in,
  input  logic [EXP_W-1:0] exp_min,
  input  logic [ACC_W-1:0] fixed_point_acc,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [IN_W-1:0]  fixed_point_in,
  output logic [EXP_W-1:0] exp_out,
  output logic [ACC_W-1:0] fixed_point_out
);

  localparam int SUM_W = 64;

  typedef enum logic {IDLE = 1'b0, ADD = 1'b1} state_t;

  state_t state_q, state_d;
  logic   load_op, write_out;

  logic             sign_q;
  logic [EXP_W-1:0] exp_min_q, exp_in_q;
  logic [ACC_W-1:0] acc_q;
  logic [IN_W-1:0]  in_q;

  logic [EXP_W-1:0] e_min, sh_a, sh_b;
  logic [SUM_W-1:0] a_al, b_al, sum;
  logic [ACC_W-1:0] result;

  // Handshake: start is sampled only in IDLE; one operation per two cycles, no backpressure.
  always_comb begin
    state_d   = state_q;
    load_op   = 1'b0;
    write_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_op = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        write_out = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q    <= 1'b0;
      exp_min_q <= '0;
      exp_in_q  <= '0;
      acc_q     <= '0;
      in_q      <= '0;
    end else if (load_op) begin
      sign_q    <= sign_in;
      exp_min_q <= exp_min;
      exp_in_q  <= exp_in;
      acc_q     <= fixed_point_acc;
      in_q      <= fixed_point_in;
    end
  end

  // Shifts never exceed 31, so 64 bits hold both aligned operands and their sum exactly.
  assign e_min = (exp_in_q < exp_min_q) ? exp_in_q : exp_min_q;
  assign sh_a  = exp_min_q - e_min;
  assign sh_b  = exp_in_q - e_min;
  assign a_al  = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q} << sh_a;
  assign b_al  = {{(SUM_W-IN_W){1'b0}}, in_q} << sh_b;
  assign sum   = sign_q ? (a_al - b_al) : (a_al + b_al);

`ifdef FP_INT_ACC_SAT_EN
  logic ovf;
  assign ovf = (sum[SUM_W-1:ACC_W-1] != {(SUM_W-ACC_W+1){sum[SUM_W-1]}});
  always_comb begin
    result = sum[ACC_W-1:0];
    if (ovf) result = sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  logic unused_sum_hi;
  assign unused_sum_hi = ^sum[SUM_W-1:ACC_W];
  assign result        = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_out         <= '0;
      fixed_point_out <= '0;
    end else if (write_out) begin
      exp_out         <= e_min;
      fixed_point_out <= result;
    end
  end

endmodule

// File: tb/tb_fp_int_acc.sv
// Self-checking bench for fp_int_acc: directed cases from the datapath's corner points plus
// randomized operations scored against an independent arithmetic model.
module tb_fp_int_acc;

  logic        clk = 1'b0;
  logic        rst, start, sign_in;
  logic [4:0]  exp_min, exp_in, exp_out;
  logic [31:0] fixed_point_acc, fixed_point_out;
  logic [13:0] fixed_point_in;

  logic [36:0] exp_q[$];
  logic [36:0] exp_v;
  int          n_tests = 0;
  int          n_fail  = 0;

  fp_int_acc dut (
    .clk(clk), .rst(rst), .start(start), .sign_in(sign_in),
    .exp_min(exp_min), .fixed_point_acc(fixed_point_acc),
    .exp_in(exp_in), .fixed_point_in(fixed_point_in),
    .exp_out(exp_out), .fixed_point_out(fixed_point_out)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] model(input logic s, input logic [4:0] ea, input logic [31:0] a,
                                        input logic [4:0] ei, input logic [13:0] i);
    longint      av, bv, sv;
    logic [4:0]  e;
    logic [31:0] r;
    e  = (ei < ea) ? ei : ea;
    av = longint'($signed(a)) <<< (ea - e);
    bv = longint'({18'd0, i}) << (ei - e);
    sv = s ? (av - bv) : (av + bv);
`ifdef FP_INT_ACC_SAT_EN
    if (sv > 64'sd2147483647)       r = 32'h7FFFFFFF;
    else if (sv < -64'sd2147483648) r = 32'h80000000;
    else                            r = sv[31:0];
`else
    r = sv[31:0];
`endif
    return {e, r};
  endfunction

  task automatic set_inputs(input logic s, input logic [4:0] ea, input logic [31:0] a,
                            input logic [4:0] ei, input logic [13:0] i);
    sign_in = s; exp_min = ea; fixed_point_acc = a; exp_in = ei; fixed_point_in = i;
  endtask

  task automatic scramble_inputs();
    set_inputs(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
               5'($urandom_range(0, 31)), 14'($urandom_range(0, 16383)));
  endtask

  // Pulses start for one cycle at a negedge; on return edge k has passed (DUT in ADD).
  task automatic launch(input logic s, input logic [4:0] ea, input logic [31:0] a,
                        input logic [4:0] ei, input logic [13:0] i);
    @(negedge clk);
    set_inputs(s, ea, a, ei, i);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    set_inputs(1'b0, 5'd3, 32'h1234, 5'd7, 14'h55);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({exp_out, fixed_point_out} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_values: got exp=%0d out=%h want exp=0 out=0", exp_out, fixed_point_out);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if ({exp_out, fixed_point_out} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_no_start: got exp=%0d out=%h want exp=0 out=0", exp_out, fixed_point_out);
    end
  endtask

  task automatic test_in_below_acc();
    exp_q.push_back({5'd15, 32'h000021F8});
    launch(1'b0, 5'd16, 32'h00000001, 5'd15, 14'h21F6);
    n_tests++;
    if ({exp_out, fixed_point_out} !== 37'd0) begin
      n_fail++;
      $display("FAIL below_not_early: got exp=%0d out=%h want exp=0 out=0", exp_out, fixed_point_out);
    end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({exp_out, fixed_point_out} !== exp_v) begin
      n_fail++;
      $display("FAIL below_result: got exp=%0d out=%h want exp=%0d out=%h",
               exp_out, fixed_point_out, exp_v[36:32], exp_v[31:0]);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if ({exp_out, fixed_point_out} !== exp_v) begin
      n_fail++;
      $display("FAIL below_hold: got exp=%0d out=%h want exp=%0d out=%h",
               exp_out, fixed_point_out, exp_v[36:32], exp_v[31:0]);
    end
  endtask

  task automatic test_in_above_acc_sub();
    exp_q.push_back({5'd16, 32'd52});
    launch(1'b1, 5'd16, 32'd100, 5'd20, 14'd3);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({exp_out, fixed_point_out} !== exp_v) begin
      n_fail++;
      $display("FAIL above_sub: got exp=%0d out=%h want exp=%0d out=%h",
               exp_out, fixed_point_out, exp_v[36:32], exp_v[31:0]);
    end
  endtask

  task automatic test_overflow();
`ifdef FP_INT_ACC_SAT_EN
    exp_q.push_back({5'd10, 32'h7FFFFFFF});
`else
    exp_q.push_back({5'd10, 32'h80000010});
`endif
    launch(1'b0, 5'd10, 32'h7FFFFFF0, 5'd10, 14'h20);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({exp_out, fixed_point_out} !== exp_v) begin
      n_fail++;
      $display("FAIL overflow: got exp=%0d out=%h want exp=%0d out=%h",
               exp_out, fixed_point_out, exp_v[36:32], exp_v[31:0]);
    end
  endtask

  task automatic test_zero_input();
    exp_q.push_back({5'd2, 32'hFFFFFFE0});
    launch(1'b1, 5'd4, 32'hFFFFFFF8, 5'd2, 14'd0);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({exp_out, fixed_point_out} !== exp_v) begin
      n_fail++;
      $display("FAIL zero_input: got exp=%0d out=%h want exp=%0d out=%h",
               exp_out, fixed_point_out, exp_v[36:32], exp_v[31:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [36:0] first;
    @(negedge clk);
    set_inputs(1'b0, 5'd8, 32'd1000, 5'd9, 14'd7);
    exp_q.push_back(model(1'b0, 5'd8, 32'd1000, 5'd9, 14'd7));
    start = 1'b1;
    @(negedge clk);
    set_inputs(1'b1, 5'd31, 32'hFFFFFF00, 5'd0, 14'h3FFF);
    exp_q.push_back(model(1'b1, 5'd31, 32'hFFFFFF00, 5'd0, 14'h3FFF));
    @(negedge clk);
    first = exp_q.pop_front();
    n_tests++;
    if ({exp_out, fixed_point_out} !== first) begin
      n_fail++;
      $display("FAIL b2b_first: got exp=%0d out=%h want exp=%0d out=%h",
               exp_out, fixed_point_out, first[36:32], first[31:0]);
    end
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    n_tests++;
    if ({exp_out, fixed_point_out} !== first) begin
      n_fail++;
      $display("FAIL b2b_gap_hold: got exp=%0d out=%h want exp=%0d out=%h",
               exp_out, fixed_point_out, first[36:32], first[31:0]);
    end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({exp_out, fixed_point_out} !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_second: got exp=%0d out=%h want exp=%0d out=%h",
               exp_out, fixed_point_out, exp_v[36:32], exp_v[31:0]);
    end
    @(negedge clk);
    n_tests++;
    if ({exp_out, fixed_point_out} !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_no_third: got exp=%0d out=%h want exp=%0d out=%h",
               exp_out, fixed_point_out, exp_v[36:32], exp_v[31:0]);
    end
  endtask

  task automatic test_reset_in_add();
    launch(1'b0, 5'd5, 32'd12345, 5'd6, 14'd99);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if ({exp_out, fixed_point_out} !== 37'd0 || dut.state_q !== dut.IDLE) begin
      n_fail++;
      $display("FAIL rst_in_add: got exp=%0d out=%h state=%0d want exp=0 out=0 state=0",
               exp_out, fixed_point_out, dut.state_q);
    end
    exp_q.push_back(model(1'b0, 5'd3, 32'd77, 5'd1, 14'd5));
    launch(1'b0, 5'd3, 32'd77, 5'd1, 14'd5);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_tests++;
    if ({exp_out, fixed_point_out} !== exp_v) begin
      n_fail++;
      $display("FAIL rst_then_op: got exp=%0d out=%h want exp=%0d out=%h",
               exp_out, fixed_point_out, exp_v[36:32], exp_v[31:0]);
    end
  endtask

  task automatic test_random();
    logic        s;
    logic [4:0]  ea, ei;
    logic [31:0] a;
    logic [13:0] i;
    for (int n = 0; n < 40; n++) begin
      s  = 1'($urandom_range(0, 1));
      ea = 5'($urandom_range(0, 31));
      ei = (n % 4 == 0) ? ea : 5'($urandom_range(0, 31));
      a  = $urandom();
      i  = 14'($urandom_range(0, 16383));
      exp_q.push_back(model(s, ea, a, ei, i));
      launch(s, ea, a, ei, i);
      @(negedge clk);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL random_%0d: scoreboard empty, got exp=%0d out=%h", n, exp_out, fixed_point_out);
      end else begin
        exp_v = exp_q.pop_front();
        if ({exp_out, fixed_point_out} !== exp_v) begin
          n_fail++;
          $display("FAIL random_%0d: got exp=%0d out=%h want exp=%0d out=%h (s=%0d ea=%0d a=%h ei=%0d i=%h)",
                   n, exp_out, fixed_point_out, exp_v[36:32], exp_v[31:0], s, ea, a, ei, i);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_below_acc();
    test_in_above_acc_sub();
    test_overflow();
    test_zero_input();
    test_back_to_back();
    test_reset_in_add();
    test_random();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
